// File: rtl/fp_convert_sequencer_if.sv
// Handshake bundle for fp_convert_sequencer: the sample input side, the float result side and busy.
// The master modport is the source/consumer environment; the slave modport is the converter.
interface fp_convert_sequencer_if #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned MAN_W = 5,
  parameter int unsigned EXP_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] D;
  logic             out_valid;
  logic             out_ready;
  logic             S;
  logic [EXP_W-1:0] E;
  logic [MAN_W-1:0] F;
  logic             busy;

  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, S, E, F, busy
  );

  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, S, E, F, busy
  );
endinterface

// File: rtl/fp_convert_sequencer.sv
// Multi-cycle two's-complement to sign/exponent/mantissa converter with valid/ready on both sides.
// Optional FPCONV_STATS_EN adds conv_count and sat outputs; core timing is unchanged by it.
module fp_convert_sequencer #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned MAN_W = 5,
  parameter int unsigned EXP_W = 4
) (
  input  logic clk,
  input  logic rst,
  fp_convert_sequencer_if.slave bus
`ifdef FPCONV_STATS_EN
  ,
  output logic [15:0] conv_count,
  output logic [0:0]  sat
`endif
);

  // Exponent counter sized to hold every shift count plus a rounding carry without wrapping.
  localparam int unsigned CntW = $clog2(WIDTH + 2);
  localparam int unsigned ExpMax = (2 ** EXP_W) - 1;

  typedef enum logic [2:0] {StIdle, StConv, StNorm, StRnd, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] mag_q;
  logic [CntW-1:0]  exp_q;
  logic             rbit_q;

  logic [MAN_W:0]   rnd_sum;
  logic [MAN_W-1:0] rnd_man;
  logic [CntW-1:0]  rnd_exp;
  logic             rnd_sat;

  always_comb begin
    rnd_sum = {1'b0, mag_q[MAN_W-1:0]} + {{MAN_W{1'b0}}, rbit_q};
    rnd_man = rnd_sum[MAN_W-1:0];
    rnd_exp = exp_q;
    if (rnd_sum[MAN_W]) begin
      rnd_man = rnd_sum[MAN_W:1];
      rnd_exp = exp_q + 1'b1;
    end
    rnd_sat = (32'(rnd_exp) > ExpMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      d_q           <= '0;
      mag_q         <= '0;
      exp_q         <= '0;
      rbit_q        <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.S         <= 1'b0;
      bus.E         <= '0;
      bus.F         <= '0;
`ifdef FPCONV_STATS_EN
      conv_count    <= '0;
      sat           <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            d_q          <= bus.D;
            state_q      <= StConv;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        StConv: begin
          // Min negative maps to 2**(WIDTH-1), which still fits as unsigned.
          mag_q   <= d_q[WIDTH-1] ? (~d_q + 1'b1) : d_q;
          exp_q   <= '0;
          rbit_q  <= 1'b0;
          state_q <= StNorm;
        end
        StNorm: begin
          if ((mag_q >> MAN_W) != '0) begin
            rbit_q <= mag_q[0];
            mag_q  <= mag_q >> 1;
            exp_q  <= exp_q + 1'b1;
          end else begin
            state_q <= StRnd;
          end
        end
        StRnd: begin
          bus.S <= d_q[WIDTH-1];
          if (rnd_sat) begin
            bus.E <= '1;
            bus.F <= '1;
          end else begin
            bus.E <= rnd_exp[EXP_W-1:0];
            bus.F <= rnd_man;
          end
`ifdef FPCONV_STATS_EN
          sat <= rnd_sat;
`endif
          bus.out_valid <= 1'b1;
          state_q       <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            state_q       <= StIdle;
`ifdef FPCONV_STATS_EN
            conv_count <= conv_count + 16'd1;
`endif
          end
        end
        default: begin
          state_q       <= StIdle;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_convert_sequencer.sv
// Directed bench for fp_convert_sequencer: conversions, latency, backpressure and mid-run reset.
module tb_fp_convert_sequencer;
  localparam int unsigned WIDTH = 13;
  localparam int unsigned MAN_W = 5;
  localparam int unsigned EXP_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fp_convert_sequencer_if #(.WIDTH(WIDTH), .MAN_W(MAN_W), .EXP_W(EXP_W)) bus ();

`ifdef FPCONV_STATS_EN
  logic [15:0] conv_count;
  logic [0:0]  sat;
`endif

  fp_convert_sequencer #(.WIDTH(WIDTH), .MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef FPCONV_STATS_EN
    ,
    .conv_count (conv_count),
    .sat        (sat)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept d, wait for out_valid within a bound, and return the observed latency.
  task automatic start_and_wait(input logic [WIDTH-1:0] d, output int lat);
    check_eq("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.D        = d;
    tick();
    bus.in_valid = 1'b0;
    bus.D        = '0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_conv(input string tag, input logic [WIDTH-1:0] d, input logic s,
                          input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f,
                          input int exp_lat);
    int lat;
    start_and_wait(d, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_S"}, 32'(bus.S), 32'(s));
    check_eq({tag, "_E"}, 32'(bus.E), 32'(e));
    check_eq({tag, "_F"}, 32'(bus.F), 32'(f));
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
    ack();
    check_eq({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, "_E_held"}, 32'(bus.E), 32'(e));
    check_eq({tag, "_F_held"}, 32'(bus.F), 32'(f));
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.D         = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_S", 32'(bus.S), 32'd0);
    check_eq("rst_E", 32'(bus.E), 32'd0);
    check_eq("rst_F", 32'(bus.F), 32'd0);
`ifdef FPCONV_STATS_EN
    check_eq("rst_count", 32'(conv_count), 32'd0);
    check_eq("rst_sat", 32'(sat), 32'd0);
`endif
    // out_ready while idle must be ignored.
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("idle_ready_ignored", 32'(bus.out_valid), 32'd0);

    run_conv("zero",   13'd0,     1'b0, 4'd0, 5'd0,  3);
    run_conv("d100",   13'd100,   1'b0, 4'd2, 5'd25, 5);
    run_conv("d63",    13'd63,    1'b0, 4'd2, 5'd16, 4);
    run_conv("minneg", 13'h1000,  1'b1, 4'd8, 5'd16, 11);
    run_conv("neg7",   13'h1FF9,  1'b1, 4'd0, 5'd7,  3);
    run_conv("d31",    13'd31,    1'b0, 4'd0, 5'd31, 3);
    run_conv("d32",    13'd32,    1'b0, 4'd1, 5'd16, 4);
    run_conv("maxpos", 13'd4095,  1'b0, 4'd8, 5'd16, 10);
`ifdef FPCONV_STATS_EN
    check_eq("count_after8", 32'(conv_count), 32'd8);
    check_eq("sat_none", 32'(sat), 32'd0);
`endif

    // Backpressure: result held for 5 clocks, a pulsed in_valid must not be taken.
    start_and_wait(13'd100, lat);
    check_eq("bp_lat", 32'(lat), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.D        = 13'd0;
      end
      tick();
      bus.in_valid = 1'b0;
      check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_E", 32'(bus.E), 32'd2);
      check_eq("bp_F", 32'(bus.F), 32'd25);
      check_eq("bp_S", 32'(bus.S), 32'd0);
    end
    ack();
    check_eq("bp_idle", 32'(bus.in_ready), 32'd1);
    tick();
    check_eq("bp_no_accept", 32'(bus.busy), 32'd0);
    run_conv("after_bp", 13'h1FF9, 1'b1, 4'd0, 5'd7, 3);

    // Reset during NORM of 4000 aborts with no out_valid.
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.D        = 13'd4000;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check_eq("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_in_ready_post", 32'(bus.in_ready), 32'd1);
    check_eq("abort_busy_post", 32'(bus.busy), 32'd0);
    check_eq("abort_S", 32'(bus.S), 32'd0);
    check_eq("abort_E", 32'(bus.E), 32'd0);
    check_eq("abort_F", 32'(bus.F), 32'd0);
`ifdef FPCONV_STATS_EN
    check_eq("abort_count", 32'(conv_count), 32'd0);
`endif
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("abort_no_ov", 32'(bus.out_valid), 32'd0);
    end
    run_conv("post_abort", 13'd100, 1'b0, 4'd2, 5'd25, 5);
`ifdef FPCONV_STATS_EN
    check_eq("count_post_abort", 32'(conv_count), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
